rgb_breathe_pwm: RTL and testbench
==================================

RGB_BREATHE_PWM -- requirements
Module: rgb_breathe_pwm

Interface
REQ-001 Parameter PWM_BITS, default 8, width of PWM counter and duty/level values.
REQ-002 Parameter DB_CYCLES, default 65536, consecutive stable cycles required to accept a button change.
REQ-003 Parameter STEP_LOG2, default 15, fade step period is 2^STEP_LOG2 clki cycles.
REQ-004 clki  input  1  single clock domain (48 MHz on board); all logic on posedge clki.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn_a  input  1  raw pulled-up pad, 0 = pressed, asynchronous; mode select.
REQ-007 btn_b  input  1  raw pulled-up pad, 0 = pressed, asynchronous; colour select.
REQ-008 pwm_r, pwm_g, pwm_b  output  1 each  PWM drive, 1 = LED on, feeds RGB driver RGB0PWM/RGB1PWM/RGB2PWM.
REQ-009 mode  output  2  current mode: 0 OFF, 1 SOLID, 2 BREATHE, 3 CYCLE.
REQ-010 colour  output  2  current colour index: 0 red, 1 green, 2 blue, 3 white.

Function
REQ-011 Each button SHALL pass a 2-flop synchronizer before any other use.
REQ-012 Debounced state SHALL change only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any agreeing sample resets the count to 0.
REQ-013 A press pulse SHALL be asserted for exactly one cycle when debounced state goes 1->0; release generates no pulse.
REQ-014 PWM counter SHALL increment every cycle, wrapping 2^PWM_BITS-1 -> 0.
REQ-015 pwm_x SHALL equal (counter < duty_x), registered; duty 0 gives constant 0, duty max gives on for 2^PWM_BITS-1 of 2^PWM_BITS cycles.
REQ-016 duty_x SHALL be loaded from the next-duty value only in the cycle the counter wraps to 0 (no mid-period duty change).
REQ-017 Press on btn_a SHALL advance mode OFF->SOLID->BREATHE->CYCLE->OFF; on mode change level SHALL reset to 0 and direction to up.
REQ-018 Press on btn_b SHALL advance colour 0->1->2->3->0 in every mode except CYCLE, where it is ignored.
REQ-019 Simultaneous btn_a and btn_b pulses in one cycle SHALL both take effect, btn_b evaluated against the pre-update mode.
REQ-020 Step prescaler SHALL produce a one-cycle step tick every 2^STEP_LOG2 cycles; level changes only on a tick.
REQ-021 BREATHE/CYCLE: on tick, level +1 when up, -1 when down; at max with up, direction flips to down and level holds that tick; at 0 with down, direction flips to up and level holds.
REQ-022 CYCLE: at each down->up flip at level 0, colour SHALL advance 0->1->2->0 (index 3 skipped; if entered with colour 3, next flip gives 0).
REQ-023 Next-duty: OFF all 0; SOLID full-scale (2^PWM_BITS-1) on selected channel(s); BREATHE/CYCLE level on selected channel(s); colour 3 drives all three channels.
REQ-024 mode and colour outputs SHALL be registered and update the cycle after the triggering pulse.

Reset
REQ-025 While rst=1: pwm_r/g/b=0, mode=0, colour=0, level=0, direction=up, PWM and prescaler counters=0, duties=0, debounced states=1, debounce counts=0, synchronizers=1.
REQ-026 Reset asserted mid-operation SHALL take effect on the next clki edge regardless of state; no press pulse SHALL be generated by reset release.

Structure
REQ-027 Mode and colour encodings SHALL be constants in a shared package rgb_pkg.
REQ-028 Synchronizer, debounce counter and press-edge detect SHALL be one sub-module btn_debounce, instantiated twice.

Verification (sim with PWM_BITS=4, DB_CYCLES=4, STEP_LOG2=2)
REQ-029 btn_a low 3 cycles then high -> no pulse, mode stays 0; btn_a low 6 cycles -> exactly one pulse, mode=1 one cycle later, no second pulse on release.
REQ-030 mode=1, colour=0 -> pwm_r high 15 of every 16 cycles, pwm_g=pwm_b=0; btn_b press -> colour=1, switch of duty from pwm_r to pwm_g occurs only at counter wrap.
REQ-031 mode=2, colour=3 -> level ramps 0..15 at one step per 4 cycles, holds one tick at 15, ramps down, holds at 0; all three PWM outputs identical.
REQ-032 mode=3, colour=2 -> after first return to 0, colour=0; btn_b press ignored, colour unchanged.
REQ-033 btn_a and btn_b pressed in same cycle with mode=2, colour=1 -> mode=3, colour=2.
REQ-034 rst pulsed for one cycle during mode=2 mid-ramp -> next cycle all outputs 0, mode=0, colour=0, and no press pulse following release.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared mode/colour encodings and channel-select helpers for the RGB breathe PWM block.
// Pure definitions: no latency, no backpressure.
package rgb_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_CYCLE   = 2'd3
  } mode_t;

  localparam logic [1:0] COL_RED   = 2'd0;
  localparam logic [1:0] COL_GREEN = 2'd1;
  localparam logic [1:0] COL_BLUE  = 2'd2;
  localparam logic [1:0] COL_WHITE = 2'd3;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_sel_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_OFF:     return MODE_SOLID;
      MODE_SOLID:   return MODE_BREATHE;
      MODE_BREATHE: return MODE_CYCLE;
      default:      return MODE_OFF;
    endcase
  endfunction

  // Auto-cycle walks red->green->blue only; white falls back to red.
  function automatic logic [1:0] cycle_colour(input logic [1:0] c);
    case (c)
      COL_RED:   return COL_GREEN;
      COL_GREEN: return COL_BLUE;
      default:   return COL_RED;
    endcase
  endfunction

  function automatic rgb_sel_t chan_sel(input logic [1:0] c);
    rgb_sel_t s;
    s.r = (c == COL_RED)   || (c == COL_WHITE);
    s.g = (c == COL_GREEN) || (c == COL_WHITE);
    s.b = (c == COL_BLUE)  || (c == COL_WHITE);
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop sync, DB_CYCLES-stable debounce, one-cycle press pulse on 1->0.
// Latency: press 2+DB_CYCLES cycles after the pad settles low; no backpressure.
module btn_debounce #(
  parameter int DB_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          db_state;
  logic [CW-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1   <= 1'b1;
      sync_2   <= 1'b1;
      db_state <= 1'b1;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 == db_state) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        db_state <= sync_2;
        db_cnt   <= '0;
        // Only the released->pressed transition pulses.
        press    <= db_state;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_breathe_pwm.sv
// RGB LED controller: button-selected mode/colour, breathing level, per-channel PWM.
// Latency: mode/colour 1 cycle after press pulse, duty applied at next PWM wrap; no backpressure.
module rgb_breathe_pwm
  import rgb_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int DB_CYCLES = 65536,
  parameter int STEP_LOG2 = 15
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       btn_a,
  input  logic       btn_b,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic [1:0] mode,
  output logic [1:0] colour
);

  localparam logic [PWM_BITS-1:0] FULL = {PWM_BITS{1'b1}};

  logic                 press_a;
  logic                 press_b;
  mode_t                mode_q,     mode_d;
  logic [1:0]           colour_q,   colour_d;
  logic [PWM_BITS-1:0]  level_q,    level_d;
  logic                 dir_down_q, dir_down_d;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [STEP_LOG2-1:0] step_cnt;
  logic                 step_tick;
  logic                 pwm_wrap;
  logic [PWM_BITS-1:0]  duty_r, duty_g, duty_b;
  logic [PWM_BITS-1:0]  nxt_r,  nxt_g,  nxt_b;
  logic [PWM_BITS-1:0]  lvl;
  rgb_sel_t             sel;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
    .clk   (clki),
    .rst   (rst),
    .btn   (btn_a),
    .press (press_a)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
    .clk   (clki),
    .rst   (rst),
    .btn   (btn_b),
    .press (press_b)
  );

  assign step_tick = &step_cnt;
  assign pwm_wrap  = &pwm_cnt;

  always_comb begin
    mode_d     = mode_q;
    colour_d   = colour_q;
    level_d    = level_q;
    dir_down_d = dir_down_q;
    // Colour press is judged against the mode before any same-cycle mode press.
    if (press_b && (mode_q != MODE_CYCLE)) begin
      colour_d = colour_q + 2'd1;
    end
    if (press_a) begin
      mode_d     = next_mode(mode_q);
      level_d    = '0;
      dir_down_d = 1'b0;
    end else if (step_tick && ((mode_q == MODE_BREATHE) || (mode_q == MODE_CYCLE))) begin
      if (!dir_down_q) begin
        if (level_q == FULL) dir_down_d = 1'b1;
        else                 level_d    = level_q + 1'b1;
      end else if (level_q == '0) begin
        dir_down_d = 1'b0;
        if (mode_q == MODE_CYCLE) colour_d = cycle_colour(colour_q);
      end else begin
        level_d = level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      mode_q     <= MODE_OFF;
      colour_q   <= COL_RED;
      level_q    <= '0;
      dir_down_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      colour_q   <= colour_d;
      level_q    <= level_d;
      dir_down_q <= dir_down_d;
    end
  end

  always_comb begin
    sel = chan_sel(colour_q);
    case (mode_q)
      MODE_OFF:   lvl = '0;
      MODE_SOLID: lvl = FULL;
      default:    lvl = level_q;
    endcase
    nxt_r = sel.r ? lvl : '0;
    nxt_g = sel.g ? lvl : '0;
    nxt_b = sel.b ? lvl : '0;
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
      duty_r   <= '0;
      duty_g   <= '0;
      duty_b   <= '0;
      pwm_r    <= 1'b0;
      pwm_g    <= 1'b0;
      pwm_b    <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      step_cnt <= step_cnt + 1'b1;
      // Duties only move on the wrap so a period is never split between two values.
      if (pwm_wrap) begin
        duty_r <= nxt_r;
        duty_g <= nxt_g;
        duty_b <= nxt_b;
      end
      pwm_r <= (pwm_cnt < duty_r);
      pwm_g <= (pwm_cnt < duty_g);
      pwm_b <= (pwm_cnt < duty_b);
    end
  end

  assign mode   = mode_q;
  assign colour = colour_q;

endmodule

// File: tb/tb_rgb_breathe_pwm.sv
// Bench for rgb_breathe_pwm with PWM_BITS=4, DB_CYCLES=4, STEP_LOG2=2.
// Button press vectors feed a mode/colour scoreboard; PWM phase and breathe ramp are checked by hand sequences.
module tb_rgb_breathe_pwm;

  logic       clki  = 1'b0;
  logic       rst   = 1'b1;
  logic       btn_a = 1'b1;
  logic       btn_b = 1'b1;
  logic       pwm_r, pwm_g, pwm_b;
  logic [1:0] mode, colour;

  int passed = 0;
  int total  = 0;
  int ph     = 0;

  rgb_breathe_pwm #(.PWM_BITS(4), .DB_CYCLES(4), .STEP_LOG2(2)) dut (
    .clki   (clki),
    .rst    (rst),
    .btn_a  (btn_a),
    .btn_b  (btn_b),
    .pwm_r  (pwm_r),
    .pwm_g  (pwm_g),
    .pwm_b  (pwm_b),
    .mode   (mode),
    .colour (colour)
  );

  always #5 clki = ~clki;

  // Expected PWM counter value: cleared by reset, free-running mod 16.
  always @(posedge clki) ph <= rst ? 0 : (ph + 1) % 16;

  typedef struct {
    logic a;
    logic b;
    int   n;
    int   exp_pa;
    int   exp_pb;
    int   exp_mode;
    int   exp_colour;
  } vec_t;

  typedef struct {
    int mode;
    int colour;
    int pa;
    int pb;
  } exp_t;

  vec_t vecs [11];
  exp_t sb [$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clki);
    #1;
  endtask

  task automatic press(input logic a, input logic b, input int n, input int win,
                       output int pa, output int pb);
    pa = 0;
    pb = 0;
    btn_a = a ? 1'b0 : 1'b1;
    btn_b = b ? 1'b0 : 1'b1;
    for (int i = 1; i <= win; i++) begin
      cyc();
      pa += int'(dut.press_a);
      pb += int'(dut.press_b);
      if (i == n) begin
        btn_a = 1'b1;
        btn_b = 1'b1;
      end
    end
  endtask

  task automatic push_exp(input int m, input int c, input int pa, input int pb);
    exp_t x;
    x.mode = m; x.colour = c; x.pa = pa; x.pb = pb;
    sb.push_back(x);
  endtask

  task automatic pop_chk(input string tag, input int pa, input int pb);
    exp_t x;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 0, 1);
    end else begin
      x = sb.pop_front();
      chk({tag, " mode"}, int'(mode), x.mode);
      chk({tag, " colour"}, int'(colour), x.colour);
      chk({tag, " press_a pulses"}, pa, x.pa);
      chk({tag, " press_b pulses"}, pb, x.pb);
    end
  endtask

  task automatic apply(input int s, input int e);
    int pa, pb;
    for (int i = s; i < e; i++) begin
      push_exp(vecs[i].exp_mode, vecs[i].exp_colour, vecs[i].exp_pa, vecs[i].exp_pb);
      press(vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].n + 12, pa, pb);
      pop_chk($sformatf("vec%0d", i), pa, pb);
    end
  endtask

  initial begin
    int pa, pb, first, mode6, mode7, rh, gh, bh, mism, prev, lv, k, last, found;

    //          a     b     n  pa pb mode col
    vecs[0]  = '{1'b1, 1'b0, 3, 0, 0, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 6, 0, 1, 1, 2};
    vecs[2]  = '{1'b0, 1'b1, 8, 0, 1, 1, 3};
    vecs[3]  = '{1'b0, 1'b1, 6, 0, 1, 2, 0};
    vecs[4]  = '{1'b0, 1'b1, 5, 0, 1, 2, 1};
    vecs[5]  = '{1'b1, 1'b1, 6, 1, 1, 3, 2};
    vecs[6]  = '{1'b0, 1'b1, 6, 0, 1, 3, 0};
    vecs[7]  = '{1'b1, 1'b0, 6, 1, 0, 0, 0};
    vecs[8]  = '{1'b1, 1'b0, 4, 1, 0, 1, 0};
    vecs[9]  = '{1'b1, 1'b0, 6, 1, 0, 2, 0};
    vecs[10] = '{1'b0, 1'b1, 6, 0, 1, 2, 1};

    // Reset state
    for (int i = 0; i < 3; i++) cyc();
    chk("reset pwm_r", int'(pwm_r), 0);
    chk("reset pwm_g", int'(pwm_g), 0);
    chk("reset pwm_b", int'(pwm_b), 0);
    chk("reset mode", int'(mode), 0);
    chk("reset colour", int'(colour), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc();

    // Glitch shorter than the debounce window
    apply(0, 1);

    // Debounced press: pulse at cycle 6, mode visible one cycle later, none on release
    pa = 0; first = -1; mode6 = -1; mode7 = -1;
    btn_a = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (dut.press_a) begin
        pa++;
        if (first < 0) first = i;
      end
      if (i == 6) begin
        mode6 = int'(mode);
        btn_a = 1'b1;
      end
      if (i == 7) mode7 = int'(mode);
    end
    chk("press pulse count", pa, 1);
    chk("press pulse cycle", first, 6);
    chk("mode in pulse cycle", mode6, 0);
    chk("mode after pulse", mode7, 1);

    // SOLID red: 15 of 16 on
    for (int i = 0; i < 16; i++) cyc();
    rh = 0; gh = 0; bh = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      rh += int'(pwm_r); gh += int'(pwm_g); bh += int'(pwm_b);
    end
    chk("solid red r highs/32", rh, 30);
    chk("solid red g highs/32", gh, 0);
    chk("solid red b highs/32", bh, 0);

    // Colour change to green lands on a period boundary
    push_exp(1, 1, 0, 1);
    press(1'b0, 1'b1, 6, 7, pa, pb);
    pop_chk("solid to green", pa, pb);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      cyc();
      if (pwm_g) begin
        found = 1;
        chk("green first-on phase", ph, 1);
      end
    end
    chk("green switch seen", found, 1);
    rh = 0; gh = int'(pwm_g); bh = 0;
    for (int i = 1; i < 16; i++) begin
      cyc();
      rh += int'(pwm_r); gh += int'(pwm_g); bh += int'(pwm_b);
    end
    chk("solid green g highs/16", gh, 15);
    chk("solid green r highs", rh, 0);
    chk("solid green b highs", bh, 0);

    apply(1, 3);

    // BREATHE white: ramp 0..15, hold, 14..0, hold, 1
    push_exp(2, 3, 1, 0);
    press(1'b1, 1'b0, 6, 7, pa, pb);
    pop_chk("enter breathe", pa, pb);
    chk("breathe start level", int'(dut.level_q), 0);
    prev = 0; k = 0; last = 0; mism = 0; rh = 0;
    for (int c = 1; c <= 400 && k < 31; c++) begin
      cyc();
      if (pwm_r != pwm_g || pwm_g != pwm_b) mism++;
      rh += int'(pwm_r);
      lv = int'(dut.level_q);
      if (lv != prev) begin
        chk($sformatf("ramp value %0d", k), lv, (k < 15) ? k + 1 : (k < 30) ? 29 - k : 1);
        if (k > 0)
          chk($sformatf("ramp interval %0d", k), c - last, (k == 15 || k == 30) ? 8 : 4);
        last = c;
        prev = lv;
        k++;
      end
    end
    chk("ramp steps seen", k, 31);
    chk("white channels differ", mism, 0);
    chk("breathe r active", int'(rh > 0), 1);

    // Colours to green, then simultaneous presses
    apply(3, 6);

    // CYCLE: first down->up flip moves blue to red
    found = 0;
    for (int c = 0; c < 400 && found == 0; c++) begin
      cyc();
      if (colour != 2'd2) found = 1;
    end
    chk("cycle flip seen", found, 1);
    chk("cycle flip colour", int'(colour), 0);
    chk("cycle flip level", int'(dut.level_q), 0);
    chk("cycle flip mode", int'(mode), 3);

    // Colour press ignored in CYCLE, then back round to BREATHE green
    apply(6, 11);

    // Reset mid-ramp
    for (int i = 0; i < 10; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midreset pwm_r", int'(pwm_r), 0);
    chk("midreset pwm_g", int'(pwm_g), 0);
    chk("midreset pwm_b", int'(pwm_b), 0);
    chk("midreset mode", int'(mode), 0);
    chk("midreset colour", int'(colour), 0);
    pa = 0; rh = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      pa += int'(dut.press_a) + int'(dut.press_b);
      rh += int'(pwm_r) + int'(pwm_g) + int'(pwm_b);
    end
    chk("pulses after reset", pa, 0);
    chk("pwm after reset", rh, 0);
    chk("mode after reset", int'(mode), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
